// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage for a 64x8 synchronous instruction memory. Owns
//               the PC, absorbs the 1-cycle memory read latency and hands
//               each instruction (with its PC and opcode class) to execute
//               over a valid/ready handshake. Supports run/stop, redirect
//               and halt on a dedicated encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int                 ADDR_W     = 6,
  parameter int                 DATA_W     = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [DATA_W-1:0]  HALT_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [1:0]        op_class,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_VALID   = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;

  // State and datapath registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic: a redirect pre-empts the normal sequence in every state,
  // so an in-flight read or a held instruction is simply dropped. When the
  // redirect lands on a transfer the instruction is still considered accepted
  // (valid falls either way), but its halt encoding is ignored.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      valid_d  = 1'b0;
      state_d  = run ? S_FETCH : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_d = S_FETCH;
        end
        S_FETCH: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          instr_d    = imem_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          valid_d    = 1'b1;
          state_d    = S_VALID;
        end
        S_VALID: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            if (instr_q == HALT_INSTR) begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end else begin
              state_d = run ? S_FETCH : S_IDLE;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign imem_we     = 1'b0;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign op_class    = instr_q[DATA_W-1 -: 2];
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch with a behavioural
//               64x8 synchronous memory and an expected-instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] imem_addr;
  logic       imem_we;
  logic [7:0] imem_data;
  logic       redirect_valid;
  logic [5:0] redirect_pc;
  logic [7:0] instr;
  logic [5:0] instr_pc;
  logic [1:0] op_class;
  logic       instr_valid;
  logic       instr_ready;
  logic       halted;

  typedef struct packed {
    logic [7:0] ins;
    logic [5:0] pc;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] mem [64];
  int         checks = 0;
  int         errors = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_we        (imem_we),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .op_class       (op_class),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one cycle of read latency.
  always @(posedge clk) imem_data <= mem[imem_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_valid(input int max_cyc, output bit got);
    int cyc = 0;
    got = 1'b0;
    while (!got && cyc < max_cyc) begin
      tick();
      cyc++;
      if (instr_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 6'd0 || halted !== 1'b0 ||
        imem_addr !== 6'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b instr=%h pc=%0d halted=%b addr=%0d we=%b, expected 0/00/0/0/0/0",
               instr_valid, instr, instr_pc, halted, imem_addr, imem_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    int cyc = 0;
    int k = 0;
    do_reset();
    sb.push_back('{8'h41, 6'd0}); sb.push_back('{8'h46, 6'd1});
    sb.push_back('{8'h4B, 6'd2}); sb.push_back('{8'h4D, 6'd3});
    run = 1'b1; instr_ready = 1'b1;
    while (k < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (instr_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (instr !== e.ins || instr_pc !== e.pc || op_class !== e.ins[7:6] || cyc != 3 * (k + 1)) begin
          errors++;
          $display("FAIL seq_item%0d: got instr=%h pc=%0d class=%0d cycle=%0d, expected instr=%h pc=%0d class=%0d cycle=%0d",
                   k, instr, instr_pc, op_class, cyc, e.ins, e.pc, e.ins[7:6], 3 * (k + 1));
        end
        k++;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL seq_timeout: got %0d deliveries, expected 4", k);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    sb.push_back('{8'h41, 6'd0}); sb.push_back('{8'h46, 6'd1}); sb.push_back('{8'h4B, 6'd2});
    run = 1'b1; instr_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wait_valid(12, got);
      e = sb.pop_front();
      checks++;
      if (!got || instr !== e.ins || instr_pc !== e.pc || op_class !== e.ins[7:6]) begin
        errors++;
        $display("FAIL bp_item%0d: got valid=%b instr=%h pc=%0d class=%0d, expected instr=%h pc=%0d class=%0d",
                 n, got, instr, instr_pc, op_class, e.ins, e.pc, e.ins[7:6]);
      end
      if (n == 1) begin
        for (int h = 0; h < 5; h++) begin
          tick();
          checks++;
          if (instr_valid !== 1'b1 || instr !== e.ins || instr_pc !== e.pc || imem_addr !== 6'd2) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b instr=%h pc=%0d addr=%0d, expected 1/%h/%0d/2",
                     h, instr_valid, instr, instr_pc, imem_addr, e.ins, e.pc);
          end
        end
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
    end
  endtask

  task automatic test_redirect();
    bit got;
    // Redirect while an instruction is held under backpressure.
    do_reset();
    run = 1'b1; instr_ready = 1'b0;
    wait_valid(12, got);
    redirect_valid = 1'b1; redirect_pc = 6'd13;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_valid_drop: got instr_valid=%b, expected 0", instr_valid);
    end
    sb.push_back('{8'hC8, 6'd13});
    instr_ready = 1'b1;
    wait_valid(12, got);
    e = sb.pop_front();
    checks++;
    if (!got || instr !== e.ins || instr_pc !== e.pc || op_class !== 2'd3) begin
      errors++;
      $display("FAIL redir_valid_target: got valid=%b instr=%h pc=%0d class=%0d, expected instr=%h pc=%0d class=3",
               got, instr, instr_pc, op_class, e.ins, e.pc);
    end

    // Redirect while the first read is in flight (CAPTURE).
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 6'd13;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_capture_drop: got instr_valid=%b instr=%h, expected 0", instr_valid, instr);
    end
    sb.push_back('{8'hC8, 6'd13});
    wait_valid(12, got);
    e = sb.pop_front();
    checks++;
    if (!got || instr !== e.ins || instr_pc !== e.pc || op_class !== e.ins[7:6]) begin
      errors++;
      $display("FAIL redir_capture_target: got valid=%b instr=%h pc=%0d class=%0d, expected instr=%h pc=%0d class=%0d",
               got, instr, instr_pc, op_class, e.ins, e.pc, e.ins[7:6]);
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    int k = 0;
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 6'd63;
    tick();
    redirect_valid = 1'b0;
    sb.push_back('{8'h81, 6'd63}); sb.push_back('{8'h41, 6'd0});
    while (k < 2 && cyc < 20) begin
      tick();
      cyc++;
      if (instr_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (instr !== e.ins || instr_pc !== e.pc || op_class !== e.ins[7:6]) begin
          errors++;
          $display("FAIL wrap_item%0d: got instr=%h pc=%0d class=%0d, expected instr=%h pc=%0d class=%0d",
                   k, instr, instr_pc, op_class, e.ins, e.pc, e.ins[7:6]);
        end
        k++;
      end
    end
    checks++;
    if (k != 2) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d deliveries, expected 2", k);
    end
  endtask

  task automatic test_halt();
    int cyc = 0;
    int k = 0;
    bit got;
    do_reset();
    for (int i = 0; i < 6; i++) sb.push_back('{mem[i], 6'(i)});
    run = 1'b1; instr_ready = 1'b1;
    while (k < 6 && cyc < 40) begin
      tick();
      cyc++;
      if (instr_valid === 1'b1) begin
        e = sb.pop_front();
        checks++;
        if (instr !== e.ins || instr_pc !== e.pc) begin
          errors++;
          $display("FAIL halt_item%0d: got instr=%h pc=%0d, expected instr=%h pc=%0d",
                   k, instr, instr_pc, e.ins, e.pc);
        end
        k++;
      end
    end
    tick();
    checks++;
    if (k != 6 || halted !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: got deliveries=%0d halted=%b valid=%b, expected 6/1/0", k, halted, instr_valid);
    end
    for (int h = 0; h < 20; h++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d: got halted=%b valid=%b, expected 1/0", h, halted, instr_valid);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 6'd0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_release: got halted=%b, expected 0", halted);
    end
    sb.push_back('{8'h41, 6'd0});
    wait_valid(12, got);
    e = sb.pop_front();
    checks++;
    if (!got || instr !== e.ins || instr_pc !== e.pc) begin
      errors++;
      $display("FAIL halt_resume: got valid=%b instr=%h pc=%0d, expected instr=%h pc=%0d",
               got, instr, instr_pc, e.ins, e.pc);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    // Reset while the second read is in CAPTURE (41 already delivered).
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    wait_valid(12, got);
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 6'd0 || halted !== 1'b0 ||
        imem_addr !== 6'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_capture: got valid=%b instr=%h pc=%0d halted=%b addr=%0d we=%b, expected 0/00/0/0/0/0",
               instr_valid, instr, instr_pc, halted, imem_addr, imem_we);
    end
    rst = 1'b0;

    // Reset while C8 at pc 13 is held valid.
    run = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 6'd13;
    tick();
    redirect_valid = 1'b0;
    wait_valid(12, got);
    rst = 1'b1;
    tick();
    checks++;
    if (!got || instr_valid !== 1'b0 || instr !== 8'h00 || instr_pc !== 6'd0 || halted !== 1'b0 ||
        imem_addr !== 6'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got seen=%b valid=%b instr=%h pc=%0d halted=%b addr=%0d we=%b, expected 1/0/00/0/0/0/0",
               got, instr_valid, instr, instr_pc, halted, imem_addr, imem_we);
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h40 + 8'(i);
    mem[0] = 8'h41; mem[1] = 8'h46; mem[2] = 8'h4B; mem[3] = 8'h4D;
    mem[5] = 8'h00; mem[13] = 8'hC8; mem[63] = 8'h81;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
